bt_pipe_host_emu: RTL
=====================

Name: bt_pipe_host_emu

Overview:
- Host-side initiator for the block-throttled pipe protocol. Drives the FPGA-facing pipe-in and pipe-out strobes the way the host interface does, so pipe sinks and sources can be exercised on `clk` without a USB host (loopback self-test, simulation).
- Runs a write phase that generates pattern words into a pipe-in sink. It then runs a read phase that pulls words from a pipe-out source and checks them against the same pattern.
- Sits beside the pipe-in/pipe-out check logic and is selected in place of the host endpoints.

Parameters:
- BLOCK_LEN, 16, words per block; power of two, 2..1024.
- GAP_CYCLES, 2, idle cycles inserted after each block before ready is sampled again; 0..255.

Ports:
- clk  in  1  pipe clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a transfer when idle.
- mode  in  1  0 = LFSR pattern, 1 = counter pattern; sampled on accepted start.
- xfer_words  in  32  words per direction; sampled on accepted start.
- wr_ready  in  1  sink can accept one full block.
- wr_strobe  out  1  write strobe; word valid on wr_data.
- wr_blockstrobe  out  1  one-cycle pulse preceding each write block.
- wr_data  out  16  write word.
- rd_ready  in  1  source has one full block available.
- rd_strobe  out  1  read strobe.
- rd_blockstrobe  out  1  one-cycle pulse preceding each read block.
- rd_data  in  16  read word; valid the cycle after the matching rd_strobe.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of transfer.
- err_count  out  16  read mismatches, saturating.
- words_done  out  32  words read and checked so far in the current transfer.

Behaviour:
- Reset: all outputs 0, state IDLE, both generators re-seeded. Reset mid-transfer aborts the transfer with no done pulse; outputs are 0 from the next edge.
- Accepted start:
  - start is accepted only in IDLE; start while busy is ignored.
  - On acceptance: latch mode; nblocks = xfer_words / BLOCK_LEN (remainder ignored); clear err_count and words_done; re-seed generators; busy = 1 next cycle.
  - nblocks = 0: go directly to DONE.
- States: IDLE, W_WAIT, W_BSTB, W_BURST, W_GAP, R_WAIT, R_BSTB, R_BURST, R_DRAIN, R_GAP, DONE.
- W_WAIT: wait for registered wr_ready = 1, then W_BSTB.
- W_BSTB: wr_blockstrobe = 1 for exactly one cycle, then W_BURST.
- W_BURST: wr_strobe = 1 for exactly BLOCK_LEN consecutive cycles. wr_data = current write-generator word; the generator advances every strobe cycle. wr_ready is not re-checked inside a block.
- W_GAP: GAP_CYCLES cycles with strobes low. Then W_WAIT if write blocks remain, else R_WAIT. With GAP_CYCLES = 0 the state is skipped.
- R_WAIT / R_BSTB / R_BURST: mirror the write path using rd_ready, rd_blockstrobe and rd_strobe.
- Read check:
  - The check happens one cycle after each rd_strobe: compare rd_data with the read-generator word, then advance the read generator.
  - On mismatch, err_count += 1, saturating at 16'hFFFF.
  - words_done += 1 per checked word.
- R_DRAIN: one cycle after the last strobe of a block, to check the final word. Then R_GAP. After R_GAP: R_WAIT if read blocks remain, else DONE.
- DONE: done = 1 and busy = 0 in the same cycle; return to IDLE next cycle. err_count and words_done hold until the next accepted start.
- Patterns (the write and read generators are identical and independent):
  - LFSR: 32-bit, seed 32'h0D0C_0B0A. Word = lfsr[15:0]. Advance: lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
  - Counter: 16-bit, seed 16'h0001, +1 per word, wraps FFFF -> 0000.
- wr_ready and rd_ready are sampled only in their WAIT states. A ready that drops during a burst has no effect.

Decomposition:
- Package bt_pipe_pkg:
  - state enum;
  - LFSR_SEED and counter-seed constants;
  - LFSR tap constant;
  - MODE_LFSR / MODE_COUNT encodings.
- Sub-module bt_pattern_gen (ports: clk, reset, seed_load, advance, mode, word[15:0]). Instantiated twice, once for write and once for read.

Test Plan:
- Write sequence: BLOCK_LEN = 16, mode = 1, xfer_words = 32, both readies tied 1.
  - Required: wr_blockstrobe pulses exactly 2 times.
  - Required: 32 wr_strobe cycles with wr_data 0001..0020.
- Read loopback and done: same setup, with a source returning the counter pattern one cycle after rd_strobe.
  - Required: err_count = 0 and words_done = 32.
  - Required: done is a single pulse; busy = 0 afterwards.
- LFSR mismatch: mode = 0, xfer_words = 16, source data corrupted at words 3 and 9 (bit 0 flipped).
  - Required: err_count = 2.
  - Required: first wr_data = 16'h0B0A.
- Throttle: rd_ready low for 50 cycles after the write phase.
  - Required: no rd_strobe or rd_blockstrobe until 1 cycle after rd_ready is seen high.
  - Required: a rd_ready drop mid-burst does not shorten the burst.
- Boundaries:
  - xfer_words = 0: done pulse 2 cycles after start, no strobes.
  - xfer_words = 17: only 16 words transferred.
  - start while busy: ignored.
- Reset mid-burst (cycle 5 of a write block): all outputs 0 the next cycle, no done pulse. A new start then replays the pattern from the seed.

Source files
------------

// File: rtl/bt_pipe_pkg.sv
// Shared types and constants for the block-throttled pipe host emulator.
package bt_pipe_pkg;

    typedef enum logic [3:0] {
        IDLE,
        W_WAIT,
        W_BSTB,
        W_BURST,
        W_GAP,
        R_WAIT,
        R_BSTB,
        R_BURST,
        R_DRAIN,
        R_GAP,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_SEED  = 32'h0D0C_0B0A;
    localparam logic [15:0] CNT_SEED   = 16'h0001;
    // Feedback taps at bits 31, 21, 1 and 0.
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

    localparam logic MODE_LFSR  = 1'b0;
    localparam logic MODE_COUNT = 1'b1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bt_pattern_gen.sv
// Pattern word generator: 32-bit LFSR or 16-bit counter, selected by mode.
module bt_pattern_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_load,
    input  logic        advance,
    input  logic        mode,
    output logic [15:0] word
);
    import bt_pipe_pkg::*;

    logic [31:0] lfsr;
    logic [15:0] cnt;

    // Both generators are seeded together so mode may change on any load.
    always_ff @(posedge clk) begin
        if (reset || seed_load) begin
            lfsr <= LFSR_SEED;
            cnt  <= CNT_SEED;
        end else if (advance) begin
            lfsr <= lfsr_next(lfsr);
            cnt  <= cnt + 16'd1;
        end
    end

    // Present the word of the selected pattern.
    always_comb begin
        word = (mode == MODE_COUNT) ? cnt : lfsr[15:0];
    end

endmodule

// File: rtl/bt_pipe_host_emu.sv
// Host-side initiator: writes pattern blocks into a pipe-in sink, then reads
// blocks back from a pipe-out source and checks them against the same pattern.
module bt_pipe_host_emu #(
    parameter int BLOCK_LEN  = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] xfer_words,
    input  logic        wr_ready,
    output logic        wr_strobe,
    output logic        wr_blockstrobe,
    output logic [15:0] wr_data,
    input  logic        rd_ready,
    output logic        rd_strobe,
    output logic        rd_blockstrobe,
    input  logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_count,
    output logic [31:0] words_done
);
    import bt_pipe_pkg::*;

    localparam int             BLK_SHIFT = $clog2(BLOCK_LEN);
    localparam int             CW        = 11;
    localparam logic [CW-1:0]  LAST_BEAT = CW'(BLOCK_LEN - 1);
    localparam logic [CW-1:0]  LAST_GAP  = CW'(GAP_CYCLES - 1);

    state_t        state, state_n;
    logic          rdy_w_q, rdy_r_q;
    logic          mode_q;
    logic [31:0]   nblocks, blk_left;
    logic [CW-1:0] cnt;
    logic          chk_en;
    logic          accept, cnt_clr, blk_dec, blk_load, w_end, r_end;
    logic [15:0]   wgen_word, rgen_word;

    bt_pattern_gen u_wgen (
        .clk       (clk),
        .reset     (reset),
        .seed_load (accept),
        .advance   (wr_strobe),
        .mode      (mode_q),
        .word      (wgen_word)
    );

    bt_pattern_gen u_rgen (
        .clk       (clk),
        .reset     (reset),
        .seed_load (accept),
        .advance   (chk_en),
        .mode      (mode_q),
        .word      (rgen_word)
    );

    // State, block/beat counters and registered ready inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rdy_w_q  <= 1'b0;
            rdy_r_q  <= 1'b0;
            mode_q   <= 1'b0;
            nblocks  <= '0;
            blk_left <= '0;
            cnt      <= '0;
            chk_en   <= 1'b0;
        end else begin
            state   <= state_n;
            rdy_w_q <= wr_ready;
            rdy_r_q <= rd_ready;
            chk_en  <= rd_strobe;
            cnt     <= cnt_clr ? '0 : cnt + 1'b1;
            if (accept) begin
                mode_q   <= mode;
                nblocks  <= xfer_words >> BLK_SHIFT;
                blk_left <= xfer_words >> BLK_SHIFT;
            end else if (blk_load) begin
                blk_left <= nblocks;
            end else if (blk_dec) begin
                blk_left <= blk_left - 32'd1;
            end
        end
    end

    // Read checker: compare the word returned one cycle after each strobe.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            err_count  <= '0;
            words_done <= '0;
        end else if (chk_en) begin
            words_done <= words_done + 32'd1;
            if (rd_data != rgen_word && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_n        = state;
        accept         = 1'b0;
        cnt_clr        = 1'b0;
        blk_dec        = 1'b0;
        blk_load       = 1'b0;
        w_end          = 1'b0;
        r_end          = 1'b0;
        wr_strobe      = 1'b0;
        wr_blockstrobe = 1'b0;
        rd_strobe      = 1'b0;
        rd_blockstrobe = 1'b0;
        done           = 1'b0;
        busy           = (state != IDLE) && (state != DONE);

        case (state)
            IDLE: if (start) begin
                accept  = 1'b1;
                state_n = W_WAIT;
            end
            W_WAIT: begin
                if (blk_left == '0)  state_n = DONE;
                else if (rdy_w_q)    state_n = W_BSTB;
            end
            W_BSTB: begin
                wr_blockstrobe = 1'b1;
                cnt_clr        = 1'b1;
                state_n        = W_BURST;
            end
            W_BURST: begin
                wr_strobe = 1'b1;
                if (cnt == LAST_BEAT) begin
                    cnt_clr = 1'b1;
                    if (GAP_CYCLES != 0) state_n = W_GAP;
                    else                 w_end   = 1'b1;
                end
            end
            W_GAP: if (cnt == LAST_GAP) begin
                cnt_clr = 1'b1;
                w_end   = 1'b1;
            end
            R_WAIT: if (rdy_r_q) state_n = R_BSTB;
            R_BSTB: begin
                rd_blockstrobe = 1'b1;
                cnt_clr        = 1'b1;
                state_n        = R_BURST;
            end
            R_BURST: begin
                rd_strobe = 1'b1;
                if (cnt == LAST_BEAT) state_n = R_DRAIN;
            end
            R_DRAIN: begin
                cnt_clr = 1'b1;
                if (GAP_CYCLES != 0) state_n = R_GAP;
                else                 r_end   = 1'b1;
            end
            R_GAP: if (cnt == LAST_GAP) begin
                cnt_clr = 1'b1;
                r_end   = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Block accounting is shared by the gap and no-gap exits of each phase.
        if (w_end) begin
            if (blk_left == 32'd1) begin
                state_n  = R_WAIT;
                blk_load = 1'b1;
            end else begin
                state_n  = W_WAIT;
                blk_dec  = 1'b1;
            end
        end
        if (r_end) begin
            if (blk_left == 32'd1) begin
                state_n  = DONE;
            end else begin
                state_n  = R_WAIT;
                blk_dec  = 1'b1;
            end
        end
    end

    // Data bus reads zero whenever no write word is being presented.
    always_comb begin
        wr_data = wr_strobe ? wgen_word : '0;
    end

endmodule
